// File: rtl/servo_pkg.sv
// Shared servo timing constants, decoder state encoding and small arithmetic helpers.
// The proportional controller uses the same microsecond constants.
package servo_pkg;

    localparam int SERVO_CLKS_PER_US   = 100;
    localparam int SERVO_TIMEOUT_US    = 25000;
    localparam int SERVO_MIN_PULSE_US  = 1000;
    localparam int SERVO_MAX_PULSE_US  = 2000;
    localparam int SERVO_FILTER_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } dec_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value, input logic en);
        logic [15:0] result;
        if (en && (value != 16'hFFFF)) begin
            result = value + 16'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    function automatic logic outside_range(input logic [15:0] value,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
        return (value < lo) || (value > hi);
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// Synchronizes the asynchronous PWM line and emits one-cycle rise/fall events.
// Optional glitch filter enabled by defining PWM_GLITCH_FILTER_EN.
module pwm_edge_sync #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    output logic rise_evt,
    output logic fall_evt
);

    logic sync1_r;
    logic sync2_r;
    logic level_s;
    logic prev_r;
    logic rise_r;
    logic fall_r;

    if (FILTER_CYCLES < 1) begin : g_cfg_err
        $error("FILTER_CYCLES must be >= 1");
    end

    // Two-flop synchronizer for the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
        end
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [CW-1:0] stab_cnt_r;
    logic          filt_r;

    // New level is adopted only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt_r <= '0;
            filt_r     <= 1'b0;
        end else if (sync2_r == filt_r) begin
            stab_cnt_r <= '0;
        end else if (stab_cnt_r == CW'(FILTER_CYCLES - 1)) begin
            stab_cnt_r <= '0;
            filt_r     <= sync2_r;
        end else begin
            stab_cnt_r <= stab_cnt_r + CW'(1);
        end
    end

    assign level_s = filt_r;
`else
    assign level_s = sync2_r;
`endif

    // Registered edge detection on the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            prev_r <= level_s;
            rise_r <= level_s & ~prev_r;
            fall_r <= ~level_s & prev_r;
        end
    end

    assign rise_evt = rise_r;
    assign fall_evt = fall_r;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Single-channel servo PWM decoder: measures high time and period in microseconds.
// Build option PWM_GLITCH_FILTER_EN enables the input glitch filter in pwm_edge_sync.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int CLKS_PER_US   = SERVO_CLKS_PER_US,
    parameter int TIMEOUT_US    = SERVO_TIMEOUT_US,
    parameter int MIN_PULSE_US  = SERVO_MIN_PULSE_US,
    parameter int MAX_PULSE_US  = SERVO_MAX_PULSE_US,
    parameter int FILTER_CYCLES = SERVO_FILTER_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [15:0] pulse_us,
    output logic [15:0] period_us,
    output logic        meas_valid,
    output logic        out_of_range,
    output logic        signal_lost
);

    localparam int PW = $clog2(CLKS_PER_US);

    if (CLKS_PER_US < 2) begin : g_cfg_err
        $error("CLKS_PER_US must be >= 2");
    end

    logic          rise_s;
    logic          fall_s;
    logic          tick_s;
    logic [15:0]   high_inc_s;
    logic [15:0]   per_inc_s;

    dec_state_e    state_r;
    dec_state_e    state_nxt_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    logic [15:0]   high_us_r;
    logic [15:0]   high_nxt_s;
    logic [15:0]   per_us_r;
    logic [15:0]   per_nxt_s;
    logic [15:0]   high_lat_r;
    logic [15:0]   high_lat_nxt_s;
    logic [15:0]   pulse_r;
    logic [15:0]   pulse_nxt_s;
    logic [15:0]   period_r;
    logic [15:0]   period_nxt_s;
    logic          valid_r;
    logic          valid_nxt_s;
    logic          oor_r;
    logic          oor_nxt_s;
    logic          lost_r;
    logic          lost_nxt_s;

    pwm_edge_sync #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .rise_evt (rise_s),
        .fall_evt (fall_s)
    );

    // Counts are taken from the incremented values so a tick landing on the edge cycle is included.
    assign tick_s     = (presc_r == PW'(CLKS_PER_US - 1));
    assign high_inc_s = sat_inc16(high_us_r, tick_s);
    assign per_inc_s  = sat_inc16(per_us_r, tick_s);

    // Next-state, counter and output logic; edges take priority over timeout.
    always_comb begin
        state_nxt_s    = state_r;
        presc_nxt_s    = tick_s ? '0 : (presc_r + PW'(1));
        high_nxt_s     = high_inc_s;
        per_nxt_s      = per_inc_s;
        high_lat_nxt_s = high_lat_r;
        pulse_nxt_s    = pulse_r;
        period_nxt_s   = period_r;
        valid_nxt_s    = 1'b0;
        oor_nxt_s      = oor_r;
        lost_nxt_s     = lost_r;

        case (state_r)
            IDLE: begin
                presc_nxt_s = '0;
                high_nxt_s  = 16'd0;
                per_nxt_s   = 16'd0;
                if (rise_s) begin
                    state_nxt_s = HIGH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HIGH: begin
                if (fall_s) begin
                    high_lat_nxt_s = high_inc_s;
                    state_nxt_s    = LOW;
                end else if (per_inc_s >= 16'(TIMEOUT_US)) begin
                    lost_nxt_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HIGH;
                end
            end
            LOW: begin
                if (rise_s) begin
                    pulse_nxt_s  = high_lat_r;
                    period_nxt_s = per_inc_s;
                    valid_nxt_s  = 1'b1;
                    oor_nxt_s    = outside_range(high_lat_r, 16'(MIN_PULSE_US), 16'(MAX_PULSE_US));
                    lost_nxt_s   = 1'b0;
                    presc_nxt_s  = '0;
                    high_nxt_s   = 16'd0;
                    per_nxt_s    = 16'd0;
                    state_nxt_s  = HIGH;
                end else if (per_inc_s >= 16'(TIMEOUT_US)) begin
                    lost_nxt_s  = 1'b1;
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOW;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            presc_r    <= '0;
            high_us_r  <= 16'd0;
            per_us_r   <= 16'd0;
            high_lat_r <= 16'd0;
            pulse_r    <= 16'd0;
            period_r   <= 16'd0;
            valid_r    <= 1'b0;
            oor_r      <= 1'b0;
            lost_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            presc_r    <= presc_nxt_s;
            high_us_r  <= high_nxt_s;
            per_us_r   <= per_nxt_s;
            high_lat_r <= high_lat_nxt_s;
            pulse_r    <= pulse_nxt_s;
            period_r   <= period_nxt_s;
            valid_r    <= valid_nxt_s;
            oor_r      <= oor_nxt_s;
            lost_r     <= lost_nxt_s;
        end
    end

    assign pulse_us     = pulse_r;
    assign period_us    = period_r;
    assign meas_valid   = valid_r;
    assign out_of_range = oor_r;
    assign signal_lost  = lost_r;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder with scaled timing (2 clk per us, 250 us timeout).
module tb_servo_pwm_decoder;

    localparam int CPU  = 2;
    localparam int TO   = 250;
    localparam int MINP = 10;
    localparam int MAXP = 20;
    localparam int FILT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [15:0] pulse_us;
    logic [15:0] period_us;
    logic        meas_valid;
    logic        out_of_range;
    logic        signal_lost;

    always #5 clk = ~clk;

    servo_pwm_decoder #(
        .CLKS_PER_US   (CPU),
        .TIMEOUT_US    (TO),
        .MIN_PULSE_US  (MINP),
        .MAX_PULSE_US  (MAXP),
        .FILTER_CYCLES (FILT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_in       (pwm_in),
        .pulse_us     (pulse_us),
        .period_us    (period_us),
        .meas_valid   (meas_valid),
        .out_of_range (out_of_range),
        .signal_lost  (signal_lost)
    );

    typedef struct {
        logic [15:0] pulse;
        logic [15:0] period;
        logic        oor;
        logic        lost;
    } obs_t;

    typedef struct {
        int   pulse;
        int   period;
        logic oor;
    } exp_t;

    typedef struct {
        int   hi;
        int   per;
        int   ep;
        int   eper;
        logic eoor;
    } vec_t;

    obs_t obs_a [0:255];
    int   obs_wr = 0;
    exp_t exp_q [$];
    int   total = 0;
    int   bad = 0;
    int   rd = 0;
    int   cyc = 0;
    int   hi_len = 0;

    // Record every strobe together with the outputs seen in that cycle.
    always @(negedge clk) begin
        if (meas_valid && (obs_wr < 256)) begin
            obs_a[obs_wr] <= '{pulse_us, period_us, out_of_range, signal_lost};
            obs_wr        <= obs_wr + 1;
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    task automatic rise(input logic push, input int ep, input int eper, input logic eoor);
        exp_t e;
        if (push) begin
            e.pulse  = ep;
            e.period = eper;
            e.oor    = eoor;
            exp_q.push_back(e);
        end
        pwm_in = 1'b1;
        cyc    = 0;
    endtask

    task automatic fall();
        pwm_in = 1'b0;
        hi_len = cyc;
    endtask

    task automatic drain();
        exp_t e;
        while (rd < obs_wr) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", int'(obs_a[rd].period), -1);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_us", int'(obs_a[rd].pulse), e.pulse);
                chk("period_us", int'(obs_a[rd].period), e.period);
                chk("out_of_range", int'(obs_a[rd].oor), int'(e.oor));
                chk("lost_at_strobe", int'(obs_a[rd].lost), 0);
            end
            rd++;
        end
    endtask

    task automatic expect_empty();
        chk("missing_strobes", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_pulse_us"}, int'(pulse_us), 0);
        chk({tag, "_period_us"}, int'(period_us), 0);
        chk({tag, "_meas_valid"}, int'(meas_valid), 0);
        chk({tag, "_out_of_range"}, int'(out_of_range), 0);
        chk({tag, "_signal_lost"}, int'(signal_lost), 0);
    endtask

    initial begin
        vec_t tbl [9];
        int   h;
        int   l;
        int   p;
        int   pe;

        tbl[0] = '{30, 400, 15, 200, 1'b0};
        tbl[1] = '{30, 400, 15, 200, 1'b0};
        tbl[2] = '{52, 400, 26, 200, 1'b1};
        tbl[3] = '{20, 400, 10, 200, 1'b0};
        tbl[4] = '{40, 300, 20, 150, 1'b0};
        tbl[5] = '{42, 300, 21, 150, 1'b1};
        tbl[6] = '{18, 250, 9, 125, 1'b1};
        tbl[7] = '{41, 301, 20, 150, 1'b0};
        tbl[8] = '{19, 500, 9, 250, 1'b1};

        rst_n  = 1'b0;
        pwm_in = 1'b0;
        step(3);
        chk_zero_outputs("reset");
        rst_n = 1'b1;
        step(5);

        // Table of periods: first rise only arms, each later rise reports the previous period.
        rise(1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].hi);
            fall();
            step(tbl[i].per - tbl[i].hi);
            rise(1'b1, tbl[i].ep, tbl[i].eper, tbl[i].eoor);
        end
        step(30);
        drain();
        expect_empty();

        // Held low after a valid period: timeout counted from the last rise.
        fall();
        step(TO * CPU - cyc);
        chk("lost_before_timeout_low", int'(signal_lost), 0);
        step(16);
        chk("lost_after_timeout_low", int'(signal_lost), 1);
        chk("pulse_kept_low_timeout", int'(pulse_us), 9);
        chk("period_kept_low_timeout", int'(period_us), 250);
        rise(1'b0, 0, 0, 1'b0);
        step(30);
        fall();
        step(370);
        rise(1'b1, 15, 200, 1'b0);
        step(20);
        drain();
        expect_empty();
        chk("lost_cleared_by_strobe", int'(signal_lost), 0);

        // Stuck high: timeout while in the high phase, outputs hold.
        step(TO * CPU - cyc);
        chk("lost_before_timeout_high", int'(signal_lost), 0);
        step(16);
        chk("lost_after_timeout_high", int'(signal_lost), 1);
        chk("pulse_kept_high_timeout", int'(pulse_us), 15);
        chk("period_kept_high_timeout", int'(period_us), 200);
        fall();
        step(20);
        drain();
        expect_empty();

        // Reset in the middle of a pulse discards the measurement.
        rise(1'b0, 0, 0, 1'b0);
        step(12);
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        step(2);
        chk_zero_outputs("midreset");
        rst_n = 1'b1;
        step(10);
        rise(1'b0, 0, 0, 1'b0);
        step(30);
        fall();
        step(370);
        rise(1'b1, 15, 200, 1'b0);
        step(20);
        drain();
        expect_empty();

        // Three-cycle glitch inside the low phase.
        step(10);
        fall();
        step(100);
`ifdef PWM_GLITCH_FILTER_EN
        pwm_in = 1'b1;
        step(3);
        pwm_in = 1'b0;
        step(267);
        rise(1'b1, 15, 200, 1'b0);
`else
        rise(1'b1, 15, 65, 1'b0);
        step(3);
        fall();
        step(267);
        rise(1'b1, 1, 135, 1'b1);
`endif
        step(20);
        drain();
        expect_empty();

        // Random periods checked against whole-microsecond floor arithmetic.
        for (int i = 0; i < 20; i++) begin
            h = int'($urandom_range(60, 16));
            l = int'($urandom_range(400, 16));
            step(h);
            fall();
            step(l);
            p  = hi_len / CPU;
            pe = cyc / CPU;
            rise(1'b1, p, pe, (p < MINP) || (p > MAXP));
        end
        step(20);
        drain();
        expect_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
